// File: rtl/data_mem_store.sv
// Byte-addressable data RAM: lane-aligned stores, registered word reads.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN suppresses and flags misaligned stores.
module data_mem_store #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 32768
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [ADDR_WIDTH-1:0] write_data_i,
  input  logic                  mem_write_i,
  input  logic                  mem_read_i,
  input  logic [1:0]            mem_type_i,
  output logic [ADDR_WIDTH-1:0] read_data_o,
  output logic                  misalign_o
);

  localparam int IW = $clog2(MEM_WORDS);

  logic [ADDR_WIDTH-1:0] mem [MEM_WORDS];

  logic [IW-1:0]         idx;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] wd;
  logic                  we;
  logic                  is_byte;
  logic                  is_half;
  logic [ADDR_WIDTH-1:0] read_data_d, read_data_q;
  logic                  misalign_d, misalign_q;
  logic                  unused_addr;

  // Upper address bits alias by design.
  assign unused_addr = ^addr_i[ADDR_WIDTH-1:IW+2];

  // Decode word index, byte enables and lane-replicated store data.
  always_comb begin
    idx     = addr_i[IW+1:2];
    is_byte = (mem_type_i == 2'b01);
    is_half = (mem_type_i == 2'b10);
    be      = 4'b1111;
    wd      = write_data_i;
    unique case (1'b1)
      is_byte: begin
        be = 4'b0001 << addr_i[1:0];
        wd = {4{write_data_i[7:0]}};
      end
      is_half: begin
        be = addr_i[1] ? 4'b1100 : 4'b0011;
        wd = {2{write_data_i[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = write_data_i;
      end
    endcase
  end

  // Store qualification and misalignment flag.
  always_comb begin
    we         = mem_write_i & rst_ni;
    misalign_d = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if ((is_half & addr_i[0]) |
        (~is_byte & ~is_half & (addr_i[1:0] != 2'b00))) begin
      we         = 1'b0;
      misalign_d = mem_write_i & rst_ni;
    end
`endif
  end

  // Read sees the array before this edge's store lands.
  always_comb begin
    read_data_d = read_data_q;
    if (!rst_ni) begin
      read_data_d = '0;
    end else if (mem_read_i) begin
      read_data_d = mem[idx];
    end
  end

  // Per-lane array write; array contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wd[8*k +: 8];
      end
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    read_data_q <= read_data_d;
    misalign_q  <= misalign_d;
  end

  assign read_data_o = read_data_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_data_mem_store.sv
// Directed scoreboard bench for data_mem_store.
// Honors DATA_MEM_MISALIGN_TRAP_EN for the misaligned-store expectations.
module tb_data_mem_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [1:0]  mem_type;
  logic [31:0] rdata;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  data_mem_store dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_i       (addr),
    .write_data_i (wdata),
    .mem_write_i  (mem_write),
    .mem_read_i   (mem_read),
    .mem_type_i   (mem_type),
    .read_data_o  (rdata),
    .misalign_o   (misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk();
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, rdata, e);
    end
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] ty);
    addr = a; wdata = d; mem_type = ty;
    mem_write = 1'b1; mem_read = 1'b0;
    step();
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string tag);
    addr = a; mem_read = 1'b1; mem_write = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    step();
    mem_read = 1'b0;
    pop_chk();
  endtask

  initial begin
    rst_n = 1'b0;
    addr = 32'h0; wdata = 32'hDEADBEEF;
    mem_type = 2'b11; mem_write = 1'b1; mem_read = 1'b1;

    for (int i = 0; i < 2; i++) begin
      step();
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_misalign", {31'h0, misalign}, 32'h0);
    end

    rst_n = 1'b1; mem_write = 1'b0; mem_read = 1'b1;
    step();
    mem_read = 1'b0;
    tests++;
    assert (rdata !== 32'hDEADBEEF) else begin
      fails++;
      $error("FAIL reset_store_suppressed: got %h expected not deadbeef",
             rdata);
    end

    st(32'h100, 32'h12345678, 2'b11);
    chk("word_store_misalign", {31'h0, misalign}, 32'h0);
    rd(32'h100, 32'h12345678, "word_load");

    st(32'h200, 32'h111111AA, 2'b01);
    st(32'h201, 32'h222222BB, 2'b01);
    st(32'h202, 32'h333333CC, 2'b01);
    st(32'h203, 32'h444444DD, 2'b01);
    rd(32'h200, 32'hDDCCBBAA, "byte_merge");

    st(32'h300, 32'hFFFFFFFF, 2'b00);
    st(32'h302, 32'hABCD1234, 2'b10);
    rd(32'h300, 32'h1234FFFF, "half_merge");

    st(32'h400, 32'h11111111, 2'b11);
    addr = 32'h400; wdata = 32'h22222222; mem_type = 2'b11;
    mem_write = 1'b1; mem_read = 1'b1;
    exp_q.push_back(32'h11111111);
    tag_q.push_back("read_before_write");
    step();
    mem_write = 1'b0; mem_read = 1'b0;
    pop_chk();
    rd(32'h400, 32'h22222222, "rbw_next_read");
    chk("load_misalign", {31'h0, misalign}, 32'h0);

    addr = 32'h100;
    step();
    chk("read_hold", rdata, 32'h22222222);

    st(32'h500, 32'h0, 2'b11);
    st(32'h502, 32'hCAFEBABE, 2'b11);
    chk("misalign_pulse", {31'h0, misalign}, {31'h0, TRAP});
    step();
    chk("misalign_clear", {31'h0, misalign}, 32'h0);
    rd(32'h500, TRAP ? 32'h0 : 32'hCAFEBABE, "misalign_read");

    st(32'h0002_0600, 32'h5A5AA5A5, 2'b11);
    rd(32'h600, 32'h5A5AA5A5, "alias_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
